// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester front end sharing one combinational ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  input  logic [7:0]         req_op,
  output logic [1:0]         rsp_valid,
  input  logic [1:0]         rsp_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic               rsp_zero,
  output logic               rsp_carry,
  output logic               rsp_overflow,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  output logic [3:0]         alu_op,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic               alu_zero,
  input  logic               alu_carry,
  input  logic               alu_overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  state_t           state;
  logic             owner;
  logic             gnt;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [3:0]       op_p0;
  logic [WIDTH-1:0] result_p1;
  logic             zero_p1;
  logic             carry_p1;
  logic             ovf_p1;

`ifdef ALU_ARB_RR_EN
  // Most recently granted requester; resets to 1 so requester 0 wins the first contention.
  logic last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (state == IDLE && |req_valid) begin
      last <= gnt;
    end
  end

  assign gnt = req_valid[1] & (~req_valid[0] | ~last);
`else
  assign gnt = req_valid[1] & ~req_valid[0];
`endif

  assign req_ready    = (rst_n && state == IDLE && |req_valid) ? (2'b01 << gnt) : 2'b00;
  assign alu_a        = a_p0;
  assign alu_b        = b_p0;
  assign alu_op       = op_p0;
  assign rsp_result   = result_p1;
  assign rsp_zero     = zero_p1;
  assign rsp_carry    = carry_p1;
  assign rsp_overflow = ovf_p1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 1'b0;
      a_p0      <= '0;
      b_p0      <= '0;
      op_p0     <= '0;
      result_p1 <= '0;
      zero_p1   <= 1'b0;
      carry_p1  <= 1'b0;
      ovf_p1    <= 1'b0;
      rsp_valid <= 2'b00;
    end else begin
      case (state)
        // Stage p0: latch the granted requester's operands once; they are never re-sampled.
        IDLE: begin
          if (|req_valid) begin
            a_p0  <= gnt ? req_a[2*WIDTH-1:WIDTH] : req_a[WIDTH-1:0];
            b_p0  <= gnt ? req_b[2*WIDTH-1:WIDTH] : req_b[WIDTH-1:0];
            op_p0 <= gnt ? req_op[7:4] : req_op[3:0];
            owner <= gnt;
            state <= EXEC;
          end
        end
        // Stage p1: capture the shared ALU's combinational outputs.
        EXEC: begin
          result_p1 <= alu_result;
          zero_p1   <= alu_zero;
          carry_p1  <= alu_carry;
          ovf_p1    <= alu_overflow;
          rsp_valid <= 2'b01 << owner;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= 2'b00;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= 2'b00;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed table, hand sequences and random traffic against a reference model.
// The bench also plays the shared ALU (0 ADD,1 SUB,2 AND,3 OR,4 XOR,5 SLL,6 SRL,7 SRA,8 SLT,9 SLTU).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [7:0]  req_op;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_carry, rsp_overflow;
  logic [31:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero, alu_carry, alu_overflow;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int model_last = 1;

  alu_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow)
  );

  always #5 clk = ~clk;

  // Returns {result, zero, carry, overflow}; carry on SUB means borrow.
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] op);
    logic [32:0] s;
    logic [31:0] r;
    logic        c, o;
    s = '0; r = '0; c = 1'b0; o = 1'b0;
    case (op)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        o = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        r = a - b; c = (a < b);
        o = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = a << b[4:0];
      4'd6: r = a >> b[4:0];
      4'd7: r = $signed(a) >>> b[4:0];
      4'd8: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd9: r = (a < b) ? 32'd1 : 32'd0;
      default: r = a ^ b ^ 32'hDEADBEEF;
    endcase
    return {r, (r == 32'd0), c, o};
  endfunction

  always_comb begin
    {alu_result, alu_zero, alu_carry, alu_overflow} = alu_model(alu_a, alu_b, alu_op);
  end

  function automatic int model_grant(input logic [1:0] v);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
`ifdef ALU_ARB_RR_EN
    return 1 - model_last;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
  endtask

  // One transaction from an idle DUT; leaves the DUT idle at a negedge.
  task automatic do_txn(input logic [1:0] v,
                        input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
                        input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
                        input int own, input bit chk_res, input logic [31:0] er,
                        input logic ez, input logic ec, input logic eo, input int dly);
    logic [1:0]  m;
    logic [31:0] held;
    m = (own == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    req_valid = v; req_a = {a1, a0}; req_b = {b1, b0}; req_op = {op1, op0};
    #1;
    check("grant", req_ready, m);
    check("idle_rsp_valid", rsp_valid, 2'b00);
    @(negedge clk);
    req_valid = 2'b00; req_a = $urandom; req_b = $urandom;
    #1;
    model_last = own;
    check("exec_alu_a", alu_a, own ? a1 : a0);
    check("exec_alu_op", alu_op, own ? op1 : op0);
    check("exec_rsp_valid", rsp_valid, 2'b00);
    @(negedge clk);
    #1;
    check("resp_valid", rsp_valid, m);
    if (chk_res) begin
      check("resp_result", rsp_result, er);
      check("resp_flags", {rsp_zero, rsp_carry, rsp_overflow}, {ez, ec, eo});
    end
    held = rsp_result;
    rsp_ready = (dly == 0) ? m : ~m;
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      #1;
      check("hold_valid", rsp_valid, m);
      check("hold_result", rsp_result, held);
      if (k == dly - 1) rsp_ready = m;
    end
    @(negedge clk);
    #1;
    check("rsp_done", rsp_valid, 2'b00);
    rsp_ready = 2'b00;
  endtask

  typedef struct {
    int          own;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    bit          chk;
    logic [31:0] res;
    logic        z, c, o;
    int          dly;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int          gcnt;
    int          gown [8];
    int          gcyc [8];
    logic [1:0]  v;
    logic [31:0] ra0, rb0, ra1, rb1;
    logic [3:0]  rop0, rop1;
    logic [34:0] r;
    int          eo;

    tbl[0]  = '{0, 4'd0, 32'h7FFFFFFF, 32'h1,        1, 32'h80000000, 1'b0, 1'b0, 1'b1, 0};
    tbl[1]  = '{1, 4'd1, 32'h5,        32'h5,        1, 32'h0,        1'b1, 1'b0, 1'b0, 4};
    tbl[2]  = '{1, 4'd9, 32'h1,        32'hFFFFFFFF, 1, 32'h1,        1'b0, 1'b0, 1'b0, 0};
    tbl[3]  = '{0, 4'd0, 32'hFFFFFFFF, 32'h1,        1, 32'h0,        1'b1, 1'b1, 1'b0, 1};
    tbl[4]  = '{1, 4'd1, 32'h0,        32'h1,        1, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 0};
    tbl[5]  = '{0, 4'd2, 32'hF0F0F0F0, 32'hFF00FF00, 1, 32'hF000F000, 1'b0, 1'b0, 1'b0, 2};
    tbl[6]  = '{0, 4'd7, 32'h80000000, 32'h4,        1, 32'hF8000000, 1'b0, 1'b0, 1'b0, 0};
    tbl[7]  = '{1, 4'd8, 32'h80000000, 32'h1,        1, 32'h1,        1'b0, 1'b0, 1'b0, 0};
    tbl[8]  = '{0, 4'hC, 32'h12345678, 32'h9,        0, 32'h0,        1'b0, 1'b0, 1'b0, 1};
    tbl[9]  = '{1, 4'd5, 32'h1,        32'd31,       1, 32'h80000000, 1'b0, 1'b0, 1'b0, 0};
    tbl[10] = '{0, 4'd4, 32'hAAAA5555, 32'hFFFF0000, 1, 32'h55555555, 1'b0, 1'b0, 1'b0, 0};
    tbl[11] = '{1, 4'd6, 32'h80000000, 32'd31,       1, 32'h1,        1'b0, 1'b0, 1'b0, 3};

    rst_n = 1'b0; req_valid = 2'b00; rsp_ready = 2'b00;
    req_a = '0; req_b = '0; req_op = '0;
    #3;
    check("reset_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow},
          '0);
    check("reset_alu", {alu_a, alu_b, alu_op}, '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_txn((tbl[i].own == 1) ? 2'b10 : 2'b01,
             tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].op,
             tbl[i].own, tbl[i].chk, tbl[i].res, tbl[i].z, tbl[i].c, tbl[i].o, tbl[i].dly);
    end

    // A waiting requester is not accepted in the cycle a response completes.
    @(negedge clk);
    req_valid = 2'b01; req_a = {32'd9, 32'd3}; req_b = {32'd2, 32'd4}; req_op = {4'd1, 4'd0};
    #1 check("seq_gnt0", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b10;
    #1 check("seq_busy_exec", req_ready, 2'b00);
    @(negedge clk);
    rsp_ready = 2'b01;
    #1 check("seq_rsp0", {rsp_valid, rsp_result}, {2'b01, 32'd7});
    check("seq_no_accept_on_complete", req_ready, 2'b00);
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("seq_idle", rsp_valid, 2'b00);
    check("seq_gnt1", req_ready, 2'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1 check("seq_rsp1", {rsp_valid, rsp_result}, {2'b10, 32'd7});
    rsp_ready = 2'b10;
    @(negedge clk);
    rsp_ready = 2'b00;
    #1 check("seq_done1", rsp_valid, 2'b00);
    model_last = 1;

    // Continuous contention: grant order and one op every 3 cycles.
    do_reset();
    gcnt = 0;
    for (int k = 0; k < 8; k++) begin gown[k] = -1; gcyc[k] = -1; end
    req_valid = 2'b11; rsp_ready = 2'b11;
    req_a = {32'd20, 32'd10}; req_b = {32'd4, 32'd3}; req_op = {4'd1, 4'd0};
    for (int c = 0; c < 12; c++) begin
      #1;
      if (req_ready != 2'b00 && gcnt < 8) begin
        gown[gcnt] = req_ready[1] ? 1 : 0;
        gcyc[gcnt] = c;
        gcnt++;
      end
      if (rsp_valid != 2'b00) check("cont_result", rsp_result, rsp_valid[1] ? 32'd16 : 32'd13);
      @(negedge clk);
    end
    req_valid = 2'b00; rsp_ready = 2'b00;
    check("cont_grant_count", gcnt, 4);
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_RR_EN
      check("cont_grant_order", gown[k], k % 2);
`else
      check("cont_grant_order", gown[k], 0);
`endif
      check("cont_grant_cycle", gcyc[k], 3 * k);
    end
`ifdef ALU_ARB_RR_EN
    model_last = 1;
`else
    model_last = 0;
`endif

    // Reset during EXEC drops the transaction.
    do_reset();
    @(negedge clk);
    req_valid = 2'b01; req_a = {32'd0, 32'h80000000}; req_b = {32'd0, 32'd4};
    req_op = {4'd0, 4'd7};
    #1 check("rst_seq_gnt", req_ready, 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    #1 check("rst_seq_exec_a", alu_a, 32'h80000000);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {req_ready, rsp_valid, rsp_result, rsp_zero, rsp_carry, rsp_overflow},
          '0);
    check("rst_mid_alu", {alu_a, alu_b, alu_op}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1 check("rst_no_rsp", {rsp_valid, req_ready}, 4'b0000);
    end
    do_txn(2'b01, 32'h80000000, 32'd4, 4'd7, 32'd0, 32'd0, 4'd0,
           0, 1, 32'hF8000000, 1'b0, 1'b0, 1'b0, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 40; i++) begin
      v    = 2'($urandom_range(1, 3));
      ra0  = $urandom; rb0 = $urandom; ra1 = $urandom; rb1 = $urandom;
      rop0 = 4'($urandom_range(0, 9));
      rop1 = 4'($urandom_range(0, 9));
      eo   = model_grant(v);
      r    = (eo == 1) ? alu_model(ra1, rb1, rop1) : alu_model(ra0, rb0, rop0);
      do_txn(v, ra0, rb0, rop0, ra1, rb1, rop1, eo, 1, r[34:3], r[2], r[1], r[0],
             int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
